// File: rtl/dcache_nway.sv
// dcache_nway: N-way set-associative, write-back, write-allocate L1 data cache with tree-PLRU
// replacement and an internal miss FSM. Define DCACHE_NWAY_PERF_EN to add hit/miss/write-back counters.
//
// state  | meaning
// IDLE   | accepting requests, combinational tag lookup on i_addr
// WB     | writing the dirty victim line back to memory
// RD     | requesting the missing line from memory
// WAIT   | waiting for the refill line (i_mem_rvalid)
// REPLAY | performing the latched access on the refilled way
// RESP   | presenting the miss response for one cycle
module dcache_nway #(
    parameter int SET_COUNT  = 4,
    parameter int N          = 4,
    parameter int LINE_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_store_type,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [LINE_WIDTH-1:0] o_mem_wdata,
`ifdef DCACHE_NWAY_PERF_EN
    output logic [31:0]           o_hit_cnt,
    output logic [31:0]           o_miss_cnt,
    output logic [31:0]           o_wb_cnt,
`endif
    input  logic                  i_mem_rvalid,
    input  logic [LINE_WIDTH-1:0] i_mem_rdata
);

    localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
    localparam int IDX_W  = $clog2(SET_COUNT);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W  = $clog2(N);
    localparam int WORDS  = LINE_WIDTH / DATA_WIDTH;
    localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WB, S_RD, S_WAIT, S_REPLAY, S_RESP} state_t;

    state_t                        state_q;
    logic [LINE_WIDTH-1:0]         data_q [SET_COUNT][N];
    logic [TAG_W-1:0]              tag_q  [SET_COUNT][N];
    logic [SET_COUNT-1:0][N-1:0]   valid_q;
    logic [SET_COUNT-1:0][N-1:0]   dirty_q;
    logic [SET_COUNT-1:0][N-2:0]   plru_q;

    logic [ADDR_WIDTH-1:0]         lat_addr;
    logic                          lat_we;
    logic [1:0]                    lat_type;
    logic [DATA_WIDTH-1:0]         lat_wdata;
    logic [WAY_W-1:0]              vic_way;

    function automatic logic [WSEL_W-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
        return WSEL_W'(a >> 3) & WSEL_W'(WORDS - 1);
    endfunction

    // Lane base is forced to natural alignment, so low address bits below the size are ignored.
    function automatic logic [DATA_WIDTH-1:0] merge_dw(input logic [DATA_WIDTH-1:0] old,
                                                       input logic [1:0] st,
                                                       input logic [2:0] boff,
                                                       input logic [DATA_WIDTH-1:0] wd);
        logic [7:0]            mask;
        logic [2:0]            base;
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] r;
        case (st)
            2'b00:   begin base = boff;                mask = 8'h01; end
            2'b01:   begin base = {boff[2:1], 1'b0};   mask = 8'h03; end
            2'b10:   begin base = {boff[2], 2'b00};    mask = 8'h0F; end
            default: begin base = 3'b000;              mask = 8'hFF; end
        endcase
        mask = mask << base;
        sh   = wd << {base, 3'b000};
        r    = old;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) r[8*b +: 8] = sh[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [N-2:0] t);
        int               node;
        logic [WAY_W-1:0] w;
        node = 0;
        w    = '0;
        for (int l = 0; l < WAY_W; l++) begin
            w[WAY_W-1-l] = t[node];
            node         = 2 * node + 1 + int'(t[node]);
        end
        return w;
    endfunction

    function automatic logic [N-2:0] plru_touch(input logic [N-2:0] t, input logic [WAY_W-1:0] w);
        int           node;
        logic         dir;
        logic [N-2:0] r;
        node = 0;
        r    = t;
        for (int l = 0; l < WAY_W; l++) begin
            dir     = w[WAY_W-1-l];
            r[node] = ~dir;
            node    = 2 * node + 1 + int'(dir);
        end
        return r;
    endfunction

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      lat_idx;
    logic [TAG_W-1:0]      lat_tag;
    logic [N-1:0]          hit_vec;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic                  inv_found;
    logic [WAY_W-1:0]      inv_way;
    logic [WAY_W-1:0]      victim;
    logic                  accept;

    assign req_idx     = i_addr[OFF_W +: IDX_W];
    assign req_tag     = i_addr[ADDR_WIDTH-1 -: TAG_W];
    assign lat_idx     = lat_addr[OFF_W +: IDX_W];
    assign lat_tag     = lat_addr[ADDR_WIDTH-1 -: TAG_W];
    assign o_req_ready = (state_q == S_IDLE);
    assign accept      = i_req_valid && o_req_ready;

    always_comb begin
        hit_vec   = '0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = N - 1; w >= 0; w--) begin
            hit_vec[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        hit    = |hit_vec;
        victim = inv_found ? inv_way : plru_victim(plru_q[req_idx]);
    end

    // One access datapath shared by IDLE hits and the post-refill replay.
    logic                  acc_replay;
    logic                  acc_fire;
    logic                  acc_we;
    logic [IDX_W-1:0]      acc_idx;
    logic [WAY_W-1:0]      acc_way;
    logic [WSEL_W-1:0]     acc_wsel;
    logic [LINE_WIDTH-1:0] acc_line;
    logic [DATA_WIDTH-1:0] old_dw;
    logic [DATA_WIDTH-1:0] new_dw;
    logic [LINE_WIDTH-1:0] new_line;
    logic                  fill_en;

    assign acc_replay = (state_q == S_REPLAY);
    assign acc_fire   = acc_replay || (accept && hit);
    assign fill_en    = (state_q == S_WAIT) && i_mem_rvalid;

    always_comb begin
        acc_we   = acc_replay ? lat_we : i_req_we;
        acc_idx  = acc_replay ? lat_idx : req_idx;
        acc_way  = acc_replay ? vic_way : hit_way;
        acc_wsel = acc_replay ? word_of(lat_addr) : word_of(i_addr);
        acc_line = data_q[acc_idx][acc_way];
        old_dw   = acc_line[acc_wsel*DATA_WIDTH +: DATA_WIDTH];
        new_dw   = acc_replay ? merge_dw(old_dw, lat_type, lat_addr[2:0], lat_wdata)
                              : merge_dw(old_dw, i_store_type, i_addr[2:0], i_write_data);
        new_line = acc_line;
        new_line[acc_wsel*DATA_WIDTH +: DATA_WIDTH] = new_dw;
    end

    always_ff @(posedge i_clk) begin
        if (fill_en) begin
            data_q[lat_idx][vic_way] <= i_mem_rdata;
            tag_q[lat_idx][vic_way]  <= lat_tag;
        end else if (acc_fire && acc_we) begin
            data_q[acc_idx][acc_way] <= new_line;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q         <= S_IDLE;
            valid_q         <= '0;
            dirty_q         <= '0;
            plru_q          <= '0;
            lat_addr        <= '0;
            lat_we          <= 1'b0;
            lat_type        <= 2'b00;
            lat_wdata       <= '0;
            vic_way         <= '0;
            o_resp_valid    <= 1'b0;
            o_read_data     <= '0;
            o_mem_req_valid <= 1'b0;
            o_mem_we        <= 1'b0;
            o_mem_addr      <= '0;
            o_mem_wdata     <= '0;
`ifdef DCACHE_NWAY_PERF_EN
            o_hit_cnt       <= '0;
            o_miss_cnt      <= '0;
            o_wb_cnt        <= '0;
`endif
        end else begin
            if (acc_fire) begin
                plru_q[acc_idx] <= plru_touch(plru_q[acc_idx], acc_way);
                if (acc_we) dirty_q[acc_idx][acc_way] <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    o_resp_valid <= 1'b0;
                    if (accept && hit) begin
                        o_resp_valid <= 1'b1;
                        o_read_data  <= old_dw;
`ifdef DCACHE_NWAY_PERF_EN
                        o_hit_cnt    <= o_hit_cnt + 32'd1;
`endif
                    end else if (accept) begin
                        lat_addr        <= i_addr;
                        lat_we          <= i_req_we;
                        lat_type        <= i_store_type;
                        lat_wdata       <= i_write_data;
                        vic_way         <= victim;
                        o_mem_req_valid <= 1'b1;
`ifdef DCACHE_NWAY_PERF_EN
                        o_miss_cnt      <= o_miss_cnt + 32'd1;
`endif
                        if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                            state_q     <= S_WB;
                            o_mem_we    <= 1'b1;
                            o_mem_addr  <= {tag_q[req_idx][victim], req_idx, {OFF_W{1'b0}}};
                            o_mem_wdata <= data_q[req_idx][victim];
                        end else begin
                            state_q    <= S_RD;
                            o_mem_we   <= 1'b0;
                            o_mem_addr <= {i_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                S_WB: begin
                    if (i_mem_req_ready) begin
                        state_q    <= S_RD;
                        o_mem_we   <= 1'b0;
                        o_mem_addr <= {lat_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
`ifdef DCACHE_NWAY_PERF_EN
                        o_wb_cnt   <= o_wb_cnt + 32'd1;
`endif
                    end
                end
                S_RD: begin
                    if (i_mem_req_ready) begin
                        state_q         <= S_WAIT;
                        o_mem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (i_mem_rvalid) begin
                        state_q                   <= S_REPLAY;
                        valid_q[lat_idx][vic_way] <= 1'b1;
                        dirty_q[lat_idx][vic_way] <= 1'b0;
                    end
                end
                S_REPLAY: begin
                    state_q      <= S_RESP;
                    o_resp_valid <= 1'b1;
                    o_read_data  <= old_dw;
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    o_resp_valid <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
- Parametrised successor to the fixed 4-way data cache: N-way set-associative, write-back, write-allocate L1 data cache.
- Generic tree-PLRU replacement for any power-of-2 N.
- Contains its own miss-handling FSM (write-back, then refill), so the core no longer sequences block writes.
- Sits between the core load/store unit (valid/ready request, one-cycle response) and the next memory level (line-sized request/response handshake).

Parameters:
- SET_COUNT, 4, number of sets; power of 2, >= 2.
- N, 4, associativity; power of 2, >= 2.
- LINE_WIDTH, 512, cache line width in bits; power of 2, multiple of DATA_WIDTH.
- ADDR_WIDTH, 64, byte address width.
- DATA_WIDTH, 64, core data width; fixed at 64.

Ports:
- i_clk  in  1  clock; one clock domain.
- i_arst  in  1  reset; asynchronous, active-high.
- i_req_valid  in  1  core request valid.
- o_req_ready  out  1  cache can accept a request; high only in IDLE.
- i_req_we  in  1  1 = store, 0 = load.
- i_store_type  in  2  00 SB, 01 SH, 10 SW, 11 SD.
- i_addr  in  ADDR_WIDTH  byte address.
- i_write_data  in  DATA_WIDTH  store data, LSB-aligned.
- o_resp_valid  out  1  one-cycle response pulse.
- o_read_data  out  DATA_WIDTH  aligned doubleword containing i_addr, pre-store value.
- o_mem_req_valid  out  1  memory request valid.
- i_mem_req_ready  in  1  memory accepts request.
- o_mem_we  out  1  1 = write-back, 0 = line read.
- o_mem_addr  out  ADDR_WIDTH  line-aligned address (offset bits zero).
- o_mem_wdata  out  LINE_WIDTH  write-back line.
- i_mem_rvalid  in  1  refill line valid.
- i_mem_rdata  in  LINE_WIDTH  refill line.

Behaviour:
- Address split: offset = log2(LINE_WIDTH/8) bits, index = log2(SET_COUNT) bits above offset, tag = remaining upper bits.
- Reset: FSM to IDLE; all valid, dirty and PLRU bits cleared; o_resp_valid = 0, o_mem_req_valid = 0, o_mem_we = 0; o_req_ready = 1 once reset deasserts. Reset mid-operation abandons any transfer.
- Lookup: combinational tag compare on i_addr in IDLE. Request accepted when i_req_valid & o_req_ready.
- Hit: o_resp_valid = 1 in the next cycle with the registered doubleword. Store data merges at the accepting edge and sets dirty. PLRU updates at that edge.
- Store lane: selected by store type with address naturally aligned. Low bits below the access size are ignored, and i_write_data[size-1:0] is written.
- Miss: latch addr, we, type, data; choose victim.
  - Victim is the lowest-index invalid way if any, else the PLRU way.
  - Next state is WB if victim is valid and dirty, else RD.
- WB: o_mem_req_valid = 1, o_mem_we = 1, o_mem_addr = {victim tag, index, 0}, o_mem_wdata = victim line. Stay until i_mem_req_ready, then go to RD.
- RD: o_mem_req_valid = 1, o_mem_we = 0, o_mem_addr = line address of the miss. On i_mem_req_ready go to WAIT.
- WAIT: on i_mem_rvalid write the line and tag to the victim way; valid = 1, dirty = 0; go to REPLAY.
- REPLAY: perform the latched access as a hit (store merges and sets dirty; PLRU updates); go to RESP.
- RESP: o_resp_valid = 1 for one cycle with data; then IDLE.
- Miss latency with memory ready immediately and rvalid one cycle after RD accept:
  - clean miss: RD, WAIT(2), REPLAY, RESP → response 5 cycles after accept;
  - dirty miss: +1 cycle.
- Memory request signals hold stable while valid and not ready.
- i_mem_rvalid outside WAIT is ignored.
- A request must not be presented as accepted while o_req_ready = 0.
- PLRU: N-1 bit tree per set, node 0 = root, children of k are 2k+1 and 2k+2.
  - Bit 0 means the victim lies in the left subtree.
  - On an access to way w, every node on w's path is set to point away from w.

Optional Feature:
- Macro: DCACHE_NWAY_PERF_EN.
- Defined: adds output ports o_hit_cnt, o_miss_cnt and o_wb_cnt, each 32 bits.
  - They count accepted hits, accepted misses and completed WB handshakes.
  - They wrap at 2^32 and reset to 0.
- Undefined: the ports and counter logic are absent; behaviour is otherwise identical.

Test Plan (all scenarios use default parameters):
- Reset, then load 0x1000 → RD request at address 0x1000 with o_mem_we never 1. Return a line whose dword0 = 0xDEADBEEF00000001 → o_resp_valid with 0xDEADBEEF00000001, 5 cycles after accept.
- After the previous scenario: SB 0xAB to 0x1003, then load 0x1000 → both hit with no memory request; each o_resp_valid comes 1 cycle after accept; the load returns 0xDEADBEEFAB000001.
- Loads to 0x0000, 0x0100, 0x0200, 0x0300 (all index 0) fill ways 0-3. Then load 0x0400 → evicts way 0 (clean, no WB). A following load of 0x0000 misses.
- SD 0x1122334455667788 to 0x2000, then miss 4 more tags into index 0 until 0x2000 is victim → WB with o_mem_we = 1, addr 0x2000, o_mem_wdata[63:0] = 0x1122334455667788, followed by RD of the new line.
- Hold i_mem_req_ready low for 5 cycles during RD → o_mem_addr and o_mem_req_valid stay stable and o_req_ready stays 0; the response follows after ready.
- Assert i_arst while in WAIT → all outputs are at reset values immediately. A later load of the same address misses and refills.
